// File: rtl/sm_pkg.sv
// Shared types and field widths for the SB/FC1 -> TC0 merge arbiter.
//   NODE_W/GEN_W/OPR_W/WEN_W : token field widths
//   sm_tok_t                 : merged token as held in the output stage
//   arb_state_t              : arbiter priority state
//   SRC_SB/SRC_FC1           : encoding of src_o
package sm_pkg;
  localparam int NODE_W = 16;
  localparam int GEN_W  = 12;
  localparam int OPR_W  = 32;
  localparam int WEN_W  = 2;

  typedef struct packed {
    logic [NODE_W-1:0] node;
    logic [GEN_W-1:0]  gen;
    logic [OPR_W-1:0]  opr0;
    logic [OPR_W-1:0]  opr1;
    logic [WEN_W-1:0]  mem_wen;
  } sm_tok_t;

  typedef enum logic {PRI_FC1 = 1'b0, PRI_SB = 1'b1} arb_state_t;

  localparam logic SRC_SB  = 1'b0;
  localparam logic SRC_FC1 = 1'b1;
endpackage

// File: rtl/sm_sat_counter.sv
// Saturating up-counter used for per-source accept statistics.
//   clk, rst : clock, async active-low reset
//   i_inc    : count one event this cycle
//   i_clr    : synchronous clear, takes precedence over i_inc
//   o_cnt    : current count, sticks at all-ones
module sm_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       r_cnt <= '0;
    else if (i_clr)                 r_cnt <= '0;
    else if (i_inc && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/sm_sync_merge_arb.sv
// Merges switch-buffer (SB) and IFIFO (FC1) tokens into one registered stream to TC0.
// FC1 normally has priority; after MAX_WAIT consecutive contention losses SB is promoted
// until it gets one token through. The output stage is a single valid/ready register.
//   clk, rst                 : clock, async active-low reset
//   en, cnt_clr              : grant enable, counter clear
//   sb_*  / *_sb_i           : SB token in, sb_ready = accepted this cycle
//   fc1_* / *_fc1_i          : FC1 token in, fc1_ready = accepted this cycle
//   o_valid/o_ready, *_o     : merged token out, src_o = origin (0 SB, 1 FC1)
//   pri_sb_o                 : arbiter currently favours SB
//   cnt_sb_o, cnt_fc1_o      : saturating accept counters
module sm_sync_merge_arb
  import sm_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cnt_clr,
  input  logic              sb_valid,
  output logic              sb_ready,
  input  logic [NODE_W-1:0] node_sb_i,
  input  logic [GEN_W-1:0]  gen_sb_i,
  input  logic [OPR_W-1:0]  opr_sb_i,
  input  logic [WEN_W-1:0]  mem_wen_sb_i,
  input  logic              fc1_valid,
  output logic              fc1_ready,
  input  logic [NODE_W-1:0] node_fc1_i,
  input  logic [GEN_W-1:0]  gen_fc1_i,
  input  logic [OPR_W-1:0]  opr0_fc1_i,
  input  logic [OPR_W-1:0]  opr1_fc1_i,
  input  logic [WEN_W-1:0]  mem_wen_fc1_i,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [NODE_W-1:0] node_o,
  output logic [GEN_W-1:0]  gen_o,
  output logic [OPR_W-1:0]  opr0_o,
  output logic [OPR_W-1:0]  opr1_o,
  output logic [WEN_W-1:0]  mem_wen_o,
  output logic              src_o,
  output logic              pri_sb_o,
  output logic [CNT_W-1:0]  cnt_sb_o,
  output logic [CNT_W-1:0]  cnt_fc1_o
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  arb_state_t        r_state, w_state_nxt;
  logic [WAIT_W-1:0] r_sb_wait, w_sb_wait_nxt;
  sm_tok_t           r_tok, w_tok_in;
  logic              r_valid, r_src;
  logic              w_load, w_sb_win, w_fc1_win, w_sb_acc, w_fc1_acc;

  // rst in the load term keeps the ready outputs low while reset is held.
  assign w_load    = rst & en & (~r_valid | o_ready);
  assign w_sb_win  = (r_state == PRI_SB) ? sb_valid : (sb_valid & ~fc1_valid);
  assign w_fc1_win = fc1_valid & ~w_sb_win;
  assign w_sb_acc  = w_load & w_sb_win;
  assign w_fc1_acc = w_load & w_fc1_win;
  assign sb_ready  = w_sb_acc;
  assign fc1_ready = w_fc1_acc;

  // Arbiter state. Everything frozen while en=0.
  always_comb begin
    w_state_nxt   = r_state;
    w_sb_wait_nxt = r_sb_wait;
    if (en) begin
      if (w_sb_acc || !sb_valid) begin
        w_sb_wait_nxt = '0;
        if (w_sb_acc) w_state_nxt = PRI_FC1;
      end else if ((r_state == PRI_FC1) && w_fc1_acc) begin
        // sb_valid is high here, so this FC1 grant is an SB contention loss
        w_sb_wait_nxt = r_sb_wait + WAIT_W'(1);
        if (w_sb_wait_nxt == WAIT_W'(MAX_WAIT)) w_state_nxt = PRI_SB;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= PRI_FC1;
      r_sb_wait <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sb_wait <= w_sb_wait_nxt;
    end
  end

  always_comb begin
    if (w_fc1_win)
      w_tok_in = '{node: node_fc1_i, gen: gen_fc1_i, opr0: opr0_fc1_i,
                   opr1: opr1_fc1_i, mem_wen: mem_wen_fc1_i};
    else
      w_tok_in = '{node: node_sb_i, gen: gen_sb_i, opr0: opr_sb_i,
                   opr1: '0, mem_wen: mem_wen_sb_i};
  end

  // Output stage: load on accept, otherwise drop valid once TC0 takes the token.
  // o_ready also drains a pending token while en=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_tok   <= '0;
      r_src   <= SRC_SB;
    end else if (w_sb_acc || w_fc1_acc) begin
      r_valid <= 1'b1;
      r_tok   <= w_tok_in;
      r_src   <= w_fc1_acc ? SRC_FC1 : SRC_SB;
    end else if (o_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid   = r_valid;
  assign node_o    = r_tok.node;
  assign gen_o     = r_tok.gen;
  assign opr0_o    = r_tok.opr0;
  assign opr1_o    = r_tok.opr1;
  assign mem_wen_o = r_tok.mem_wen;
  assign src_o     = r_src;
  assign pri_sb_o  = (r_state == PRI_SB);

  sm_sat_counter #(.CNT_W(CNT_W)) u_cnt_sb (
    .clk(clk), .rst(rst), .i_inc(w_sb_acc), .i_clr(cnt_clr), .o_cnt(cnt_sb_o)
  );

  sm_sat_counter #(.CNT_W(CNT_W)) u_cnt_fc1 (
    .clk(clk), .rst(rst), .i_inc(w_fc1_acc), .i_clr(cnt_clr), .o_cnt(cnt_fc1_o)
  );
endmodule
